// File: rtl/ddr_arbiter.sv
// Three-client arbiter (display read, draw write, aux read) sharing one DDR controller port.
// One DDR operation in flight; level handshakes on every side.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no owner; grants the winning pending client unless a DDR ack is still high
// ISSUE   | DDR request driven with latched address/data, waiting for the matching ack
// RELEASE | client ack high; waits for DDR ack and client request to both fall

module ddr_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk133_p,
    input  logic        rst,
    input  logic        dispRead,
    input  logic [23:0] dispAddress,
    output logic        dispAck,
    output logic [15:0] dispData,
    input  logic        drawWrite,
    input  logic [23:0] drawAddress,
    input  logic [15:0] drawData,
    output logic        drawAck,
    input  logic        auxRead,
    input  logic [23:0] auxAddress,
    output logic        auxAck,
    output logic [15:0] auxData,
    output logic        ddrRead,
    output logic [23:0] ddrReadAddress,
    input  logic        ddrReadAcknowledge,
    input  logic [15:0] ddrReadData,
    output logic        ddrWrite,
    output logic [23:0] ddrWriteAddress,
    output logic [15:0] ddrWriteData,
    input  logic        ddrWriteAcknowledge,
    output logic [1:0]  grantId,
    output logic        timeoutError
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STARVE_MAX  = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_DISP = 2'd1;
    localparam logic [1:0] GNT_DRAW = 2'd2;
    localparam logic [1:0] GNT_AUX  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          ddr_read_q, ddr_read_d;
    logic          ddr_write_q, ddr_write_d;
    logic [23:0]   rd_addr_q, rd_addr_d;
    logic [23:0]   wr_addr_q, wr_addr_d;
    logic [15:0]   wr_data_q, wr_data_d;
    logic          disp_ack_q, disp_ack_d;
    logic          draw_ack_q, draw_ack_d;
    logic          aux_ack_q, aux_ack_d;
    logic [15:0]   disp_data_q, disp_data_d;
    logic [15:0]   aux_data_q, aux_data_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
    logic          timeout_err_q, timeout_err_d;

    logic       disp_pend, draw_pend, aux_pend, other_pend;
    logic       ddr_ack_any, ddr_done, owner_req;
    logic [1:0] pick;

    always_comb begin
        disp_pend   = dispRead & ~disp_ack_q;
        draw_pend   = drawWrite & ~draw_ack_q;
        aux_pend    = auxRead & ~aux_ack_q;
        other_pend  = draw_pend | aux_pend;
        ddr_ack_any = ddrReadAcknowledge | ddrWriteAcknowledge;
        ddr_done    = (ddr_read_q & ddrReadAcknowledge) | (ddr_write_q & ddrWriteAcknowledge);

        // Once display has won STARVE_LIMIT grants in a row, a waiting client jumps the queue.
        pick = GNT_NONE;
        if ((starve_q == STARVE_MAX) && other_pend) begin
            pick = draw_pend ? GNT_DRAW : GNT_AUX;
        end else if (disp_pend) begin
            pick = GNT_DISP;
        end else if (draw_pend) begin
            pick = GNT_DRAW;
        end else if (aux_pend) begin
            pick = GNT_AUX;
        end

        case (grant_q)
            GNT_DISP: owner_req = dispRead;
            GNT_DRAW: owner_req = drawWrite;
            GNT_AUX:  owner_req = auxRead;
            default:  owner_req = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ddr_read_d    = ddr_read_q;
        ddr_write_d   = ddr_write_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        disp_ack_d    = disp_ack_q;
        draw_ack_d    = draw_ack_q;
        aux_ack_d     = aux_ack_q;
        disp_data_d   = disp_data_q;
        aux_data_d    = aux_data_q;
        starve_d      = starve_q;
        timeout_cnt_d = timeout_cnt_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                // A DDR ack still high here is stale (e.g. left over across a reset).
                if (!ddr_ack_any && (pick != GNT_NONE)) begin
                    grant_d       = pick;
                    state_d       = ST_ISSUE;
                    timeout_cnt_d = '0;
                    case (pick)
                        GNT_DISP: begin
                            ddr_read_d = 1'b1;
                            rd_addr_d  = dispAddress;
                            if (other_pend && (starve_q != STARVE_MAX)) begin
                                starve_d = starve_q + 1'b1;
                            end
                        end
                        GNT_DRAW: begin
                            ddr_write_d = 1'b1;
                            wr_addr_d   = drawAddress;
                            wr_data_d   = drawData;
                            starve_d    = '0;
                        end
                        default: begin
                            ddr_read_d = 1'b1;
                            rd_addr_d  = auxAddress;
                            starve_d   = '0;
                        end
                    endcase
                end
            end

            ST_ISSUE: begin
                if (ddr_done) begin
                    ddr_read_d  = 1'b0;
                    ddr_write_d = 1'b0;
                    state_d     = ST_RELEASE;
                    case (grant_q)
                        GNT_DISP: begin
                            disp_ack_d  = 1'b1;
                            disp_data_d = ddrReadData;
                        end
                        GNT_DRAW: draw_ack_d = 1'b1;
                        GNT_AUX: begin
                            aux_ack_d  = 1'b1;
                            aux_data_d = ddrReadData;
                        end
                        default: ;
                    endcase
                end else if (timeout_cnt_q != TIMEOUT_MAX) begin
                    timeout_cnt_d = timeout_cnt_q + 1'b1;
                end
            end

            ST_RELEASE: begin
                if (!ddr_ack_any && !owner_req) begin
                    disp_ack_d = 1'b0;
                    draw_ack_d = 1'b0;
                    aux_ack_d  = 1'b0;
                    grant_d    = GNT_NONE;
                    state_d    = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // The arbiter keeps waiting after a timeout; the flag only reports it.
        if (timeout_cnt_d == TIMEOUT_MAX) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk133_p) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= GNT_NONE;
            ddr_read_q    <= 1'b0;
            ddr_write_q   <= 1'b0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            disp_ack_q    <= 1'b0;
            draw_ack_q    <= 1'b0;
            aux_ack_q     <= 1'b0;
            disp_data_q   <= '0;
            aux_data_q    <= '0;
            starve_q      <= '0;
            timeout_cnt_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            ddr_read_q    <= ddr_read_d;
            ddr_write_q   <= ddr_write_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            disp_ack_q    <= disp_ack_d;
            draw_ack_q    <= draw_ack_d;
            aux_ack_q     <= aux_ack_d;
            disp_data_q   <= disp_data_d;
            aux_data_q    <= aux_data_d;
            starve_q      <= starve_d;
            timeout_cnt_q <= timeout_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign dispAck         = disp_ack_q;
    assign dispData        = disp_data_q;
    assign drawAck         = draw_ack_q;
    assign auxAck          = aux_ack_q;
    assign auxData         = aux_data_q;
    assign ddrRead         = ddr_read_q;
    assign ddrReadAddress  = rd_addr_q;
    assign ddrWrite        = ddr_write_q;
    assign ddrWriteAddress = wr_addr_q;
    assign ddrWriteData    = wr_data_q;
    assign grantId         = grant_q;
    assign timeoutError    = timeout_err_q;

endmodule

// File: doc/ddr_arbiter.md
DDR_ARBITER -- requirements
Module: ddr_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: consecutive display grants allowed while another client waits.
REQ-002 Parameter TIMEOUT_CYCLES, default 1023: ISSUE-state cycles before timeout flag sets.
REQ-003 clk133_p  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 dispRead / dispAddress  in  1 / 24  display read request (level) and word address.
REQ-006 dispAck / dispData  out  1 / 16  display acknowledge and read data.
REQ-007 drawWrite / drawAddress / drawData  in  1 / 24 / 16  drawing write request, address and data.
REQ-008 drawAck  out  1  drawing write acknowledge.
REQ-009 auxRead / auxAddress  in  1 / 24  auxiliary read request and address.
REQ-010 auxAck / auxData  out  1 / 16  auxiliary acknowledge and read data.
REQ-011 ddrRead / ddrReadAddress  out  1 / 24  read request and address to DDR controller.
REQ-012 ddrReadAcknowledge / ddrReadData  in  1 / 16  DDR read acknowledge and data.
REQ-013 ddrWrite / ddrWriteAddress / ddrWriteData  out  1 / 24 / 16  write request, address and data to DDR controller.
REQ-014 ddrWriteAcknowledge  in  1  DDR write acknowledge.
REQ-015 grantId  out  2  current owner: 0 none, 1 display, 2 draw, 3 aux.
REQ-016 timeoutError  out  1  sticky DDR-ack timeout flag.

Function
REQ-017 Handshake on every port is level-based: requester holds request, address and data stable until ack=1; ack stays 1 until request drops; ack clears the cycle after that.
REQ-018 At most one DDR operation outstanding; ddrRead and ddrWrite never both 1.
REQ-019 FSM states: IDLE, ISSUE, RELEASE.
REQ-020 IDLE: no grant when ddrReadAcknowledge=1 or ddrWriteAcknowledge=1; otherwise a pending client (request=1, own ack=0) is granted.
REQ-021 Grant: latch address/data/id; next cycle ddrRead or ddrWrite=1 with latched values, grantId set, state ISSUE; latency 1 cycle from request sampled to DDR request.
REQ-022 Priority display > draw > aux, except when the starvation counter equals STARVE_LIMIT and draw or aux is pending: draw (else aux) wins.
REQ-023 Starvation counter: +1 per display grant while draw or aux pending, saturating at STARVE_LIMIT; cleared on any draw/aux grant.
REQ-024 ISSUE: on matching DDR ack=1, drop the DDR request, set client ack, capture ddrReadData into that client's data register (reads only), go RELEASE, all in that cycle.
REQ-025 RELEASE: when DDR ack=0 and client request=0, clear client ack and grantId, return to IDLE; the same cycle performs no new grant.
REQ-026 dispData/auxData hold their value until that client's next completed read; never updated by another client's read.
REQ-027 Timeout counter runs only in ISSUE, clears on entry; reaching TIMEOUT_CYCLES sets timeoutError; FSM keeps waiting (no abort).
REQ-028 Client dropping request while in ISSUE: operation still completes at DDR; ack pulses 1 cycle, then clears via REQ-025.

Reset
REQ-029 rst=1: state IDLE; all request/ack outputs, grantId, timeoutError, starvation and timeout counters 0; all address/data outputs 0.
REQ-030 Reset mid-operation abandons the transfer; REQ-020 blocks new grants until a stale DDR ack falls.

Verification
REQ-031 dispRead=1 addr 0x000100, DDR acks after 5 cycles with 0xBEEF -> ddrRead next cycle, dispData=0xBEEF with dispAck=1, ack clears 1 cycle after dispRead and DDR ack low.
REQ-032 All three request same cycle -> order display, draw, aux; grantId 1,2,3.
REQ-033 Display re-requests continuously, draw held -> draw granted after exactly 8 display grants.
REQ-034 drawWrite addr 0xABCDEF data 0x1234 -> ddrWrite=1, ddrWriteAddress=0xABCDEF, ddrWriteData=0x1234, ddrRead=0 throughout.
REQ-035 DDR never acks -> timeoutError=1 after 1023 ISSUE cycles, stays 1 until rst.
REQ-036 rst during ISSUE while ddrReadAcknowledge held 1 for 3 cycles -> outputs 0, no grant until ack falls, then pending request granted.
